// File: rtl/lsu_wb_bridge.sv
// ---------------------------------------------------------------------------
// lsu_wb_bridge
//
// MEM-stage load/store unit that turns one RV32I load or store into a single
// Wishbone-classic transaction. It generates byte selects and lane-replicated
// store data, sign/zero-extends load data, and stalls the pipeline until the
// bus acknowledges. Misaligned or illegal accesses are flagged and never reach
// the bus.
//
// Optional feature (macro LSU_TIMEOUT_EN): abort a bus cycle that waits
// TIMEOUT_CYCLES cycles without ack, pulse o_bus_err, and return 0 for loads.
// Without the macro the bus waits indefinitely and o_bus_err is tied 0.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   i_req_M           MEM-stage instruction is a load/store
//   i_mem_write_M     1 = store, 0 = load
//   i_addr_M          byte address
//   i_write_data_M    right-aligned store data
//   i_funct3_M        access size / sign
//   o_read_data_M     registered, extended load result
//   o_stall_M         pipeline freeze request
//   o_misaligned      one-cycle pulse for misaligned/illegal access
//   o_bus_err         one-cycle pulse on timeout abort
//   o_wb_*, i_wb_*    Wishbone-classic master interface
//
// Handshake: a transaction is accepted in IDLE when i_req_M is high and the
// access is legal; cyc/stb then stay high until the first cycle i_wb_ack is
// sampled high (or a timeout fires), and drop at that same edge.
// ---------------------------------------------------------------------------
module lsu_wb_bridge #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_M,
  input  logic                  i_mem_write_M,
  input  logic [ADDR_WIDTH-1:0] i_addr_M,
  input  logic [DATA_WIDTH-1:0] i_write_data_M,
  input  logic [2:0]            i_funct3_M,
  output logic [DATA_WIDTH-1:0] o_read_data_M,
  output logic                  o_stall_M,
  output logic                  o_misaligned,
  output logic                  o_bus_err,
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  output logic                  o_wb_we,
  output logic [3:0]            o_wb_sel,
  output logic [ADDR_WIDTH-1:0] o_wb_adr,
  output logic [DATA_WIDTH-1:0] o_wb_dat,
  input  logic [DATA_WIDTH-1:0] i_wb_dat,
  input  logic                  i_wb_ack
);

  if (DATA_WIDTH != 32) begin : g_bad_width
    $error("lsu_wb_bridge supports DATA_WIDTH = 32 only");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("lsu_wb_bridge TIMEOUT_CYCLES must be 1..255");
  end

  typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

  state_t                state_q, state_d;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [3:0]            sel_q;
  logic [31:0]           dat_q;
  logic [2:0]            f3_q;
  logic [1:0]            off_q;
  logic [31:0]           rdata_q;

  logic                  legal;
  logic                  accept;
  logic                  timeout_hit;
  logic [3:0]            sel_d;
  logic [31:0]           wdat_d;
  logic [31:0]           shifted;
  logic [31:0]           load_fmt;

  // Legality: half needs addr[0]=0, word needs addr[1:0]=0, funct3 011/110/111
  // are not loads/stores, and stores have no unsigned variants.
  always_comb begin
    legal = 1'b1;
    case (i_funct3_M)
      3'b001, 3'b101: if (i_addr_M[0]) legal = 1'b0;
      3'b010:         if (i_addr_M[1:0] != 2'b00) legal = 1'b0;
      3'b011, 3'b110, 3'b111: legal = 1'b0;
      default:        legal = 1'b1;
    endcase
    if (i_mem_write_M && i_funct3_M[2]) legal = 1'b0;
  end

  // Byte selects and lane-replicated store data; replication puts the
  // operand on every lane so sel alone picks the right one.
  always_comb begin
    sel_d  = 4'b1111;
    wdat_d = i_write_data_M;
    case (i_funct3_M[1:0])
      2'b00: begin
        sel_d  = 4'b0001 << i_addr_M[1:0];
        wdat_d = {4{i_write_data_M[7:0]}};
      end
      2'b01: begin
        sel_d  = 4'b0011 << i_addr_M[1:0];
        wdat_d = {2{i_write_data_M[15:0]}};
      end
      default: begin
        sel_d  = 4'b1111;
        wdat_d = i_write_data_M;
      end
    endcase
  end

  // Load formatting from the latched offset and funct3.
  always_comb begin
    shifted  = i_wb_dat >> {off_q, 3'b000};
    load_fmt = shifted;
    case (f3_q)
      3'b000:  load_fmt = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_fmt = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_fmt = {24'h0, shifted[7:0]};
      3'b101:  load_fmt = {16'h0, shifted[15:0]};
      default: load_fmt = shifted;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  logic [7:0] tmo_q;

  // Ack wins over a simultaneous timeout.
  assign timeout_hit = (state_q == BUS) && !i_wb_ack &&
                       (tmo_q == 8'(TIMEOUT_CYCLES - 1));

  // Held at 0 outside BUS so it reads 0 in the first BUS cycle.
  always_ff @(posedge clk) begin
    if (rst)                tmo_q <= 8'h0;
    else if (state_q != BUS) tmo_q <= 8'h0;
    else if (!i_wb_ack)     tmo_q <= tmo_q + 8'h1;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and combinational outputs.
  always_comb begin
    state_d      = state_q;
    accept       = 1'b0;
    o_stall_M    = 1'b0;
    o_misaligned = 1'b0;
    o_bus_err    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_req_M) begin
          if (legal) begin
            accept    = 1'b1;
            o_stall_M = 1'b1;
            state_d   = BUS;
          end else begin
            o_misaligned = 1'b1;
          end
        end
      end
      BUS: begin
        o_stall_M = 1'b1;
        if (i_wb_ack) begin
          state_d = DONE;
        end else if (timeout_hit) begin
          o_bus_err = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      adr_q   <= '0;
      sel_q   <= 4'h0;
      dat_q   <= 32'h0;
      f3_q    <= 3'h0;
      off_q   <= 2'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q  <= i_mem_write_M;
        adr_q <= {i_addr_M[ADDR_WIDTH-1:2], 2'b00};
        sel_q <= sel_d;
        dat_q <= wdat_d;
        f3_q  <= i_funct3_M;
        off_q <= i_addr_M[1:0];
      end
      if (state_q == BUS && !we_q) begin
        if (i_wb_ack)         rdata_q <= load_fmt;
        else if (timeout_hit) rdata_q <= 32'h0;
      end
    end
  end

  assign o_wb_cyc      = (state_q == BUS);
  assign o_wb_stb      = (state_q == BUS);
  assign o_wb_we       = we_q & (state_q == BUS);
  assign o_wb_sel      = sel_q;
  assign o_wb_adr      = adr_q;
  assign o_wb_dat      = dat_q;
  assign o_read_data_M = rdata_q;

endmodule

// File: tb/tb_lsu_wb_bridge.sv
module tb_lsu_wb_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req_M = 1'b0;
  logic        i_mem_write_M = 1'b0;
  logic [31:0] i_addr_M = 32'h0;
  logic [31:0] i_write_data_M = 32'h0;
  logic [2:0]  i_funct3_M = 3'h0;
  logic [31:0] o_read_data_M;
  logic        o_stall_M, o_misaligned, o_bus_err;
  logic        o_wb_cyc, o_wb_stb, o_wb_we;
  logic [3:0]  o_wb_sel;
  logic [31:0] o_wb_adr, o_wb_dat;
  logic [31:0] i_wb_dat = 32'h0;
  logic        i_wb_ack = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  lsu_wb_bridge #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .i_req_M(i_req_M), .i_mem_write_M(i_mem_write_M), .i_addr_M(i_addr_M),
    .i_write_data_M(i_write_data_M), .i_funct3_M(i_funct3_M),
    .o_read_data_M(o_read_data_M), .o_stall_M(o_stall_M),
    .o_misaligned(o_misaligned), .o_bus_err(o_bus_err),
    .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb), .o_wb_we(o_wb_we),
    .o_wb_sel(o_wb_sel), .o_wb_adr(o_wb_adr), .o_wb_dat(o_wb_dat),
    .i_wb_dat(i_wb_dat), .i_wb_ack(i_wb_ack)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver: issue one access starting in IDLE (caller sits at posedge+1),
  // ack on the n_bus-th cycle cyc is high (n_bus=0: never ack). Returns the
  // bus fields seen in the first BUS cycle, stall/cyc/err counts, and the
  // read data and cyc seen in the DONE cycle. Ends at posedge+1 in IDLE.
  task automatic bus_access(
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  f3,
    input  int          n_bus,
    input  logic [31:0] rword,
    output logic [31:0] adr,
    output logic [3:0]  sel,
    output logic [31:0] dat,
    output logic        wev,
    output int          stall_cnt,
    output int          cyc_cnt,
    output int          err_cnt,
    output logic [31:0] rd,
    output logic        done_cyc
  );
    int t;
    stall_cnt = 0; cyc_cnt = 0; err_cnt = 0;
    adr = 32'hx; sel = 4'hx; dat = 32'hx; wev = 1'bx;
    i_req_M = 1'b1; i_mem_write_M = we; i_addr_M = addr;
    i_write_data_M = wdata; i_funct3_M = f3;
    t = 0;
    while (t < 40) begin
      #1;
      if (!o_stall_M) break;
      stall_cnt++;
      if (o_bus_err) err_cnt++;
      if (o_wb_cyc) begin
        cyc_cnt++;
        if (cyc_cnt == 1) begin
          adr = o_wb_adr; sel = o_wb_sel; dat = o_wb_dat; wev = o_wb_we;
        end
        if (cyc_cnt == n_bus) begin
          i_wb_ack = 1'b1; i_wb_dat = rword;
        end
      end
      @(posedge clk); #1;
      i_wb_ack = 1'b0;
      t++;
    end
    rd = o_read_data_M;
    done_cyc = o_wb_cyc;
    i_req_M = 1'b0;
    @(posedge clk); #1;
  endtask

  logic [31:0] a_adr, a_dat, a_rd;
  logic [3:0]  a_sel;
  logic        a_we, a_done_cyc;
  int          a_stall, a_cyc, a_err;

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    n_checks++; if (o_wb_cyc !== 1'b0 || o_wb_stb !== 1'b0) begin n_fail++;
      $display("FAIL reset_cyc_stb: got %b%b exp 00", o_wb_cyc, o_wb_stb); end
    n_checks++; if (o_read_data_M !== 32'h0) begin n_fail++;
      $display("FAIL reset_rdata: got %h exp 00000000", o_read_data_M); end
    n_checks++; if ({o_stall_M, o_misaligned, o_bus_err, o_wb_we} !== 4'b0) begin n_fail++;
      $display("FAIL reset_flags: got %b exp 0000", {o_stall_M, o_misaligned, o_bus_err, o_wb_we}); end
    n_checks++; if (o_wb_sel !== 4'h0 || o_wb_adr !== 32'h0 || o_wb_dat !== 32'h0) begin n_fail++;
      $display("FAIL reset_bus_fields: got sel %h adr %h dat %h exp 0", o_wb_sel, o_wb_adr, o_wb_dat); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_store;
    bus_access(1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 2, 32'h0,
               a_adr, a_sel, a_dat, a_we, a_stall, a_cyc, a_err, a_rd, a_done_cyc);
    n_checks++; if (a_adr !== 32'h100 || a_sel !== 4'b1111 || a_we !== 1'b1) begin n_fail++;
      $display("FAIL sw_adr_sel_we: got %h %b %b exp 00000100 1111 1", a_adr, a_sel, a_we); end
    n_checks++; if (a_dat !== 32'hDEADBEEF) begin n_fail++;
      $display("FAIL sw_dat: got %h exp deadbeef", a_dat); end
    n_checks++; if (a_stall !== 3 || a_cyc !== 2) begin n_fail++;
      $display("FAIL sw_stall_cyc: got %0d %0d exp 3 2", a_stall, a_cyc); end
    n_checks++; if (a_done_cyc !== 1'b0 || a_err !== 0 || a_rd !== 32'h0) begin n_fail++;
      $display("FAIL sw_done: got cyc %b err %0d rd %h exp 0 0 0", a_done_cyc, a_err, a_rd); end
    bus_access(1'b1, 32'h103, 32'h000000A5, 3'b000, 1, 32'h0,
               a_adr, a_sel, a_dat, a_we, a_stall, a_cyc, a_err, a_rd, a_done_cyc);
    n_checks++; if (a_sel !== 4'b1000 || a_dat !== 32'hA5A5A5A5 || a_adr !== 32'h100) begin n_fail++;
      $display("FAIL sb: got sel %b dat %h adr %h exp 1000 a5a5a5a5 00000100", a_sel, a_dat, a_adr); end
    n_checks++; if (a_stall !== 2) begin n_fail++;
      $display("FAIL sb_min_stall: got %0d exp 2", a_stall); end
    bus_access(1'b1, 32'h102, 32'h00001234, 3'b001, 1, 32'h0,
               a_adr, a_sel, a_dat, a_we, a_stall, a_cyc, a_err, a_rd, a_done_cyc);
    n_checks++; if (a_sel !== 4'b1100 || a_dat !== 32'h12341234 || a_adr !== 32'h100) begin n_fail++;
      $display("FAIL sh: got sel %b dat %h adr %h exp 1100 12341234 00000100", a_sel, a_dat, a_adr); end
  endtask

  task automatic test_load;
    logic [31:0] addrs [5] = '{32'h101, 32'h102, 32'h103, 32'h102, 32'h100};
    logic [2:0]  f3s   [5] = '{3'b000, 3'b000, 3'b100, 3'b001, 3'b101};
    logic [31:0] exps  [5] = '{32'h0000007F, 32'hFFFFFFF1, 32'h00000080, 32'hFFFF80F1, 32'h00007F02};
    logic [3:0]  sels  [5] = '{4'b0010, 4'b0100, 4'b1000, 4'b1100, 4'b0011};
    for (int i = 0; i < 5; i++) begin
      bus_access(1'b0, addrs[i], 32'h0, f3s[i], 1 + i % 2, 32'h80F17F02,
                 a_adr, a_sel, a_dat, a_we, a_stall, a_cyc, a_err, a_rd, a_done_cyc);
      n_checks++; if (a_rd !== exps[i]) begin n_fail++;
        $display("FAIL load_data[%0d]: got %h exp %h", i, a_rd, exps[i]); end
      n_checks++; if (a_sel !== sels[i] || a_we !== 1'b0) begin n_fail++;
        $display("FAIL load_sel[%0d]: got %b we %b exp %b we 0", i, a_sel, a_we, sels[i]); end
    end
    bus_access(1'b0, 32'h104, 32'h0, 3'b010, 1, 32'h13579BDF,
               a_adr, a_sel, a_dat, a_we, a_stall, a_cyc, a_err, a_rd, a_done_cyc);
    n_checks++; if (a_rd !== 32'h13579BDF || a_adr !== 32'h104 || a_stall !== 2) begin n_fail++;
      $display("FAIL lw: got rd %h adr %h stall %0d exp 13579bdf 00000104 2", a_rd, a_adr, a_stall); end
    // A store must leave the last load result untouched.
    bus_access(1'b1, 32'h108, 32'h55555555, 3'b010, 1, 32'hFFFFFFFF,
               a_adr, a_sel, a_dat, a_we, a_stall, a_cyc, a_err, a_rd, a_done_cyc);
    n_checks++; if (a_rd !== 32'h13579BDF) begin n_fail++;
      $display("FAIL store_keeps_rdata: got %h exp 13579bdf", a_rd); end
  endtask

  task automatic test_misaligned;
    logic        wes   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [31:0] addrs [5] = '{32'h102, 32'h101, 32'h100, 32'h100, 32'h104};
    logic [2:0]  f3s   [5] = '{3'b010, 3'b001, 3'b011, 3'b100, 3'b110};
    for (int i = 0; i < 5; i++) begin
      i_req_M = 1'b1; i_mem_write_M = wes[i]; i_addr_M = addrs[i];
      i_funct3_M = f3s[i]; i_write_data_M = 32'hFFFFFFFF;
      #1;
      n_checks++; if (o_misaligned !== 1'b1 || o_stall_M !== 1'b0 || o_wb_cyc !== 1'b0) begin n_fail++;
        $display("FAIL illegal[%0d]: got mis %b stall %b cyc %b exp 1 0 0", i, o_misaligned, o_stall_M, o_wb_cyc); end
      @(posedge clk); #1;
      i_req_M = 1'b0;
      #1;
      n_checks++; if (o_wb_cyc !== 1'b0 || o_misaligned !== 1'b0 || o_read_data_M !== 32'h13579BDF) begin n_fail++;
        $display("FAIL illegal_after[%0d]: got cyc %b mis %b rd %h exp 0 0 13579bdf", i, o_wb_cyc, o_misaligned, o_read_data_M); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ack_outside;
    i_wb_ack = 1'b1; i_wb_dat = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (o_wb_cyc !== 1'b0 || o_stall_M !== 1'b0 || o_read_data_M !== 32'h13579BDF) begin n_fail++;
      $display("FAIL ack_idle: got cyc %b stall %b rd %h exp 0 0 13579bdf", o_wb_cyc, o_stall_M, o_read_data_M); end
    i_wb_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    i_req_M = 1'b1; i_mem_write_M = 1'b0; i_addr_M = 32'h200; i_funct3_M = 3'b010;
    @(posedge clk); #1;
    n_checks++; if (o_wb_cyc !== 1'b1) begin n_fail++;
      $display("FAIL rstmid_in_bus: got cyc %b exp 1", o_wb_cyc); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; i_req_M = 1'b0; i_wb_ack = 1'b1; i_wb_dat = 32'hA5A5A5A5;
    #1;
    n_checks++; if (o_wb_cyc !== 1'b0 || o_wb_stb !== 1'b0 || o_stall_M !== 1'b0 || o_read_data_M !== 32'h0) begin n_fail++;
      $display("FAIL rstmid_after: got cyc %b stb %b stall %b rd %h exp 0 0 0 0", o_wb_cyc, o_wb_stb, o_stall_M, o_read_data_M); end
    @(posedge clk); #1;
    i_wb_ack = 1'b0;
    #1;
    n_checks++; if (o_wb_cyc !== 1'b0 || o_read_data_M !== 32'h0) begin n_fail++;
      $display("FAIL rstmid_late_ack: got cyc %b rd %h exp 0 0", o_wb_cyc, o_read_data_M); end
    @(posedge clk); #1;
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout;
    bus_access(1'b0, 32'h104, 32'h0, 3'b010, 1, 32'hCAFEF00D,
               a_adr, a_sel, a_dat, a_we, a_stall, a_cyc, a_err, a_rd, a_done_cyc);
    n_checks++; if (a_rd !== 32'hCAFEF00D) begin n_fail++;
      $display("FAIL tmo_preload: got %h exp cafef00d", a_rd); end
    bus_access(1'b0, 32'h300, 32'h0, 3'b010, 0, 32'h0,
               a_adr, a_sel, a_dat, a_we, a_stall, a_cyc, a_err, a_rd, a_done_cyc);
    n_checks++; if (a_cyc !== 4 || a_err !== 1 || a_rd !== 32'h0) begin n_fail++;
      $display("FAIL tmo_abort: got cyc %0d err %0d rd %h exp 4 1 0", a_cyc, a_err, a_rd); end
    bus_access(1'b0, 32'h300, 32'h0, 3'b010, 4, 32'h11223344,
               a_adr, a_sel, a_dat, a_we, a_stall, a_cyc, a_err, a_rd, a_done_cyc);
    n_checks++; if (a_cyc !== 4 || a_err !== 0 || a_rd !== 32'h11223344) begin n_fail++;
      $display("FAIL tmo_ack_wins: got cyc %0d err %0d rd %h exp 4 0 11223344", a_cyc, a_err, a_rd); end
  endtask
`endif

  initial begin
    test_reset;
    test_store;
    test_load;
    test_misaligned;
    test_ack_outside;
    test_reset_mid;
`ifdef LSU_TIMEOUT_EN
    test_timeout;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_wb_bridge.md
Name: lsu_wb_bridge

Overview:
Memory-stage load/store unit sitting directly downstream of the datapath's MEM-stage outputs (address, write data, mem-write, funct3). It converts each RV32I load/store into a single Wishbone-classic bus transaction and generates byte selects and lane-replicated store data. It sign- or zero-extends load data and holds the pipeline with a stall request until the bus acknowledges. Misaligned and illegal accesses are rejected without touching the bus.

Parameters:
DATA_WIDTH, 32, data/bus width; only 32 is supported.
ADDR_WIDTH, 32, byte address width.
TIMEOUT_CYCLES, 255, maximum wait for ack in BUS state; used only with LSU_TIMEOUT_EN; 8-bit counter, legal range 1..255.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
i_req_M  in  1  MEM-stage instruction is a load or store
i_mem_write_M  in  1  1 = store, 0 = load
i_addr_M  in  ADDR_WIDTH  byte address (ALU result)
i_write_data_M  in  DATA_WIDTH  store data (rs2), right-aligned
i_funct3_M  in  3  access size/sign
o_read_data_M  out  DATA_WIDTH  extended load result
o_stall_M  out  1  freeze all pipeline stages while high
o_misaligned  out  1  one-cycle pulse: misaligned or illegal funct3
o_bus_err  out  1  one-cycle pulse: timeout abort
o_wb_cyc  out  1  Wishbone cycle
o_wb_stb  out  1  Wishbone strobe
o_wb_we  out  1  Wishbone write enable
o_wb_sel  out  4  byte lane selects
o_wb_adr  out  ADDR_WIDTH  word-aligned address; bits [1:0] = 0
o_wb_dat  out  DATA_WIDTH  write data
i_wb_dat  in  DATA_WIDTH  read data
i_wb_ack  in  1  acknowledge

Behaviour:
- Reset: state IDLE. All outputs 0, o_read_data_M = 0, timeout counter = 0. Reset asserted mid-transaction drops cyc/stb at that edge; a late ack is ignored.
- FSM states: IDLE, BUS, DONE.
- IDLE, i_req_M=1, access legal:
  - Latch we, word address, sel, shifted data, funct3 and offset = addr[1:0].
  - Go to BUS; cyc/stb are registered high from the next cycle.
  - o_stall_M is high combinationally in this same cycle.
- IDLE, i_req_M=1, access illegal:
  - o_misaligned=1 combinationally for that cycle; o_stall_M=0; no bus cycle; o_read_data_M unchanged.
  - Illegal means: half with addr[0]=1; word with addr[1:0]≠0; funct3 in {011, 110, 111}; store with funct3 bit2=1.
- BUS: cyc=stb=1, o_stall_M=1.
  - On i_wb_ack: drop cyc/stb at the same edge, capture the formatted load data (loads only), go to DONE.
  - Ack in the first BUS cycle is legal, giving a minimum 2-cycle stall.
- DONE: o_stall_M=0 for exactly one cycle so the pipeline advances. i_req_M is ignored (it is the same instruction). Next state IDLE.
- Acks outside BUS are ignored.
- Byte selects: byte → 0001<<off; half → 0011<<off; word → 1111.
- Store data: SB replicates the byte to all 4 lanes; SH replicates the half to both halves; SW passes through.
- Load formatting: data is shifted right by 8*off.
  - 000 LB: sign-extend bit 7.
  - 001 LH: sign-extend bit 15.
  - 010 LW: passes through.
  - 100 LBU, 101 LHU: zero-extend.
- o_read_data_M is registered and held until the next load completes. Stores do not modify it.
- Load-to-use latency: data is valid in the DONE cycle.

Optional Feature:
LSU_TIMEOUT_EN:
- Defined:
  - An 8-bit counter clears on entering BUS and increments each BUS cycle without ack.
  - When the counter equals TIMEOUT_CYCLES-1 with no ack, drop cyc/stb, pulse o_bus_err, and go to DONE.
  - A load aborted this way sets o_read_data_M=0.
  - Ack and timeout in the same cycle: ack wins.
- Undefined: BUS waits indefinitely; o_bus_err tied 0; no counter logic.

Test Plan:
- SW addr 0x100 data 0xDEADBEEF, ack after 2 cycles → adr=0x100, sel=1111, we=1, dat=0xDEADBEEF; stall high 3 cycles, then one DONE cycle.
- SB addr 0x103 data 0x000000A5 → sel=1000, dat=0xA5A5A5A5; SH addr 0x102 data 0x1234 → sel=1100, dat=0x12341234.
- Bus word 0x80F17F02: LB 0x101 → 0x0000007F; LB 0x102 → 0xFFFFFFF1; LBU 0x103 → 0x00000080; LH 0x102 → 0xFFFF80F1; LHU 0x100 → 0x00007F02.
- LW 0x102, then LH 0x101 → o_misaligned pulses each, cyc never asserted, stall 0, read data unchanged.
- rst during BUS with ack arriving the next cycle → cyc/stb 0 after the reset edge, state IDLE, read data 0, ack ignored.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack → cyc high 4 cycles, o_bus_err one pulse, read data 0; ack in the 4th cycle → normal completion, no o_bus_err.
